// File: rtl/dncnt_pkg.sv
// Shared types and helpers for the dncnt loadable down counter.
package dncnt_pkg;

  localparam int DNBND_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int bnd);
    return (bnd < 1) ? 1 : $clog2(bnd + 1);
  endfunction

endpackage

// File: rtl/dncnt.sv
// Loadable down counter/timer with one-cycle done pulse.
// Optional auto-reload mode enabled by defining DNCNT_RELOAD_EN.
module dncnt
  import dncnt_pkg::*;
#(
  parameter int  DNBND = DNBND_DEF,
  localparam int W     = cnt_w(DNBND)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [W-1:0] BND = W'(DNBND);

  state_t       state, nxt_state;
  logic [W-1:0] nxt_cnt;
  logic [W-1:0] ld_val;
  logic         nxt_done;
  logic         ld;

  assign ld_val = (i_ld_val > BND) ? BND : i_ld_val;

`ifdef DNCNT_RELOAD_EN
  logic [W-1:0] reload_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)   reload_q <= '0;
    else if (ld) reload_q <= ld_val;
  end
`endif

  always_comb begin
    nxt_state = state;
    nxt_cnt   = o_cnt;
    nxt_done  = 1'b0;
    ld        = 1'b0;
    if (i_clr) begin
      nxt_state = ST_IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            nxt_state = ST_RUN;
            nxt_cnt   = ld_val;
            ld        = 1'b1;
          end
        end
        ST_RUN: begin
          if (i_en) begin
            if (o_cnt != '0) begin
              nxt_cnt = o_cnt - 1'b1;
            end else begin
`ifdef DNCNT_RELOAD_EN
              // Reload in place; the pulse marks the wrap instead of a DONE state.
              nxt_cnt  = reload_q;
              nxt_done = 1'b1;
`else
              nxt_state = ST_DONE;
              nxt_done  = 1'b1;
`endif
            end
          end
        end
        ST_DONE: begin
          if (i_start) begin
            nxt_state = ST_RUN;
            nxt_cnt   = ld_val;
            ld        = 1'b1;
          end else begin
            nxt_state = ST_IDLE;
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      o_cnt  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= nxt_state;
      o_cnt  <= nxt_cnt;
      o_busy <= (nxt_state == ST_RUN);
      o_done <= nxt_done;
    end
  end

endmodule
